// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot-time program loader.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream big-endian into 32-bit words, writes them to
// instruction memory at 0,4,8,... and holds the core in reset until the load completes.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  imem_loader_if.slave      io_bus,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-2:0] o_word_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_t;

  localparam logic [ADDR_W-1:0] LP_ADDR_LAST = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [ADDR_W-1:0] LP_ADDR_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-2:0] LP_CNT_ONE   = {{(ADDR_W-2){1'b0}}, 1'b1};

  state_t            r_state, w_state_nxt;
  logic              r_in_ready, r_mem_we, r_cpu_rst, r_done, r_err, r_last, r_full;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
  logic [31:0]       r_mem_wdata, w_wdata_nxt, r_shift, w_shift_nxt, w_packed;
  logic [ADDR_W-2:0] r_word_cnt, w_cnt_nxt;
  logic [1:0]        r_byte_idx, w_idx_nxt;
  logic              w_err_nxt, w_last_nxt, w_full_nxt, w_accept;

  assign w_accept = io_bus.in_valid & r_in_ready;
  // Drop the new byte into its big-endian slot; unreceived low bytes stay zero.
  assign w_packed = r_shift | ({io_bus.in_data, 24'h00_0000} >> {r_byte_idx, 3'b000});

  // Next-state and next-register values.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_word_cnt;
    w_idx_nxt   = r_byte_idx;
    w_err_nxt   = r_err;
    w_last_nxt  = r_last;
    w_full_nxt  = r_full;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_LOAD;
          w_addr_nxt  = '0;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 2'b00;
          w_shift_nxt = 32'h0000_0000;
          w_err_nxt   = 1'b0;
          w_last_nxt  = 1'b0;
          w_full_nxt  = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOAD: begin
        if (!w_accept) begin
          w_state_nxt = ST_LOAD;
        end else if (r_full) begin
          // Memory exhausted: swallow the rest of the program without writing.
          w_err_nxt = 1'b1;
          if (io_bus.in_last) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end else if (io_bus.in_last || (r_byte_idx == 2'd3)) begin
          w_state_nxt = ST_WRITE;
          w_wdata_nxt = w_packed;
          w_last_nxt  = io_bus.in_last;
          w_shift_nxt = 32'h0000_0000;
          w_idx_nxt   = 2'b00;
        end else begin
          w_shift_nxt = w_packed;
          w_idx_nxt   = r_byte_idx + 2'd1;
        end
      end
      ST_WRITE: begin
        w_cnt_nxt = r_word_cnt + LP_CNT_ONE;
        if (r_mem_addr == LP_ADDR_LAST) begin
          w_full_nxt = 1'b1;
        end else begin
          w_addr_nxt = r_mem_addr + LP_ADDR_STEP;
        end
        if (r_last) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; outputs are registered from the next state so none is combinational.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_cpu_rst   <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_word_cnt  <= '0;
      r_byte_idx  <= 2'b00;
      r_shift     <= 32'h0000_0000;
      r_last      <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_LOAD);
      r_mem_we    <= (w_state_nxt == ST_WRITE);
      r_cpu_rst   <= (w_state_nxt != ST_DONE);
      r_done      <= (w_state_nxt == ST_DONE);
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_err       <= w_err_nxt;
      r_word_cnt  <= w_cnt_nxt;
      r_byte_idx  <= w_idx_nxt;
      r_shift     <= w_shift_nxt;
      r_last      <= w_last_nxt;
      r_full      <= w_full_nxt;
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign o_cpu_rst        = r_cpu_rst;
  assign o_done           = r_done;
  assign o_err            = r_err;
  assign o_word_cnt       = r_word_cnt;

endmodule
